// File: rtl/issue_scoreboard.sv
// issue_scoreboard: long-latency busy tracking and issue stall for a dual-issue pipeline.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle completion release dependent instructions.
module issue_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid1,
    input  logic            issue_valid2,
    input  logic [4:0]      rs11_num,
    input  logic [4:0]      rs12_num,
    input  logic [4:0]      rs21_num,
    input  logic [4:0]      rs22_num,
    input  logic            rs11_use,
    input  logic            rs12_use,
    input  logic            rs21_use,
    input  logic            rs22_use,
    input  logic [4:0]      rd1_num,
    input  logic [4:0]      rd2_num,
    input  logic            reg_we1,
    input  logic            reg_we2,
    input  logic            long1,
    input  logic            long2,
    input  logic            cmp_valid1,
    input  logic            cmp_valid2,
    input  logic [4:0]      cmp_rd1,
    input  logic [4:0]      cmp_rd2,
    input  logic            flush,
    output logic            stall1,
    output logic            stall2,
    output logic [NREG-1:0] busy_vec,
    output logic [CNTW-1:0] busy_count
);
    logic [NREG-1:0] busy_q, busy_d, clr, set, eff;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            intra, set1, set2;

    assign clr = (NREG'(cmp_valid1) << cmp_rd1) | (NREG'(cmp_valid2) << cmp_rd2);

`ifdef SCOREBOARD_BYPASS_EN
    assign eff = busy_q & ~clr;
`else
    assign eff = busy_q;
`endif

    // Slot 2 depends on slot 1's result or target: split the bundle.
    assign intra = issue_valid1 & reg_we1 & (rd1_num != 5'd0) &
                   ((rs21_use & (rs21_num == rd1_num)) |
                    (rs22_use & (rs22_num == rd1_num)) |
                    (reg_we2 & (rd2_num == rd1_num)));

    assign stall1 = issue_valid1 & ((rs11_use & eff[rs11_num]) |
                                    (rs12_use & eff[rs12_num]) |
                                    (reg_we1 & eff[rd1_num]));

    assign stall2 = issue_valid2 & (stall1 | intra |
                                    (rs21_use & eff[rs21_num]) |
                                    (rs22_use & eff[rs22_num]) |
                                    (reg_we2 & eff[rd2_num]));

    assign set1 = issue_valid1 & ~stall1 & reg_we1 & long1;
    assign set2 = issue_valid2 & ~stall2 & reg_we2 & long2;
    assign set  = (NREG'(set1) << rd1_num) | (NREG'(set2) << rd2_num);

    always_comb begin
        busy_d = flush ? '0 : ((busy_q & ~clr) | set) & ~NREG'(1);
        cnt_d  = '0;
        for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CNTW'(busy_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = cnt_q;
endmodule
